// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: per-register in-flight write counters that gate issue
// on RAW hazards and on per-register write-count saturation.
module reg_scoreboard #(
  parameter int rfWidth = 3,
  parameter int maxPend = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issueValid,
  input  logic [rfWidth-1:0]      issueOp1,
  input  logic [rfWidth-1:0]      issueOp2,
  input  logic                    issueWriteEn,
  input  logic [rfWidth-1:0]      issueDst,
  output logic                    issueReady,
  output logic                    stall,
  input  logic                    wbWriteEn,
  input  logic [rfWidth-1:0]      wbAddr,
  input  logic                    killValid,
  input  logic [rfWidth-1:0]      killAddr,
  output logic [2**rfWidth-1:0]   busy,
  output logic                    underflow
);

  localparam int NREG = 2**rfWidth;
  localparam logic [1:0] MAX_CNT = 2'(maxPend);

  logic [NREG-1:1][1:0] r_count;
  logic [NREG-1:1][1:0] w_count_nxt;
  logic [NREG-1:1]      w_uf_vec;
  logic [NREG-1:0][1:0] w_count_rd;
  logic                 r_underflow;
  logic                 w_ready;
  logic                 w_inc_en;

  // Register 0 reads as a permanently empty counter.
  always_comb begin
    w_count_rd[0] = 2'd0;
    for (int i = 1; i < NREG; i++) w_count_rd[i] = r_count[i];
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_ready = 1'b1;
    if (issueOp1 != '0 && w_count_rd[issueOp1] != 2'd0) w_ready = 1'b0;
    if (issueOp2 != '0 && w_count_rd[issueOp2] != 2'd0) w_ready = 1'b0;
    if (issueWriteEn && issueDst != '0 && w_count_rd[issueDst] == MAX_CNT) w_ready = 1'b0;
  end

  assign issueReady = w_ready;
  assign stall      = issueValid & ~w_ready;
  assign w_inc_en   = issueValid & w_ready & issueWriteEn;

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    logic       w_inc;
    logic       w_wb;
    logic       w_kill;
    logic [2:0] w_up;
    logic [2:0] w_dn;

    assign w_inc  = w_inc_en  && (issueDst == rfWidth'(g));
    assign w_wb   = wbWriteEn && (wbAddr   == rfWidth'(g));
    assign w_kill = killValid && (killAddr == rfWidth'(g));
    assign w_up   = {1'b0, r_count[g]} + {2'b00, w_inc};
    assign w_dn   = {2'b00, w_wb} + {2'b00, w_kill};

    // Net change of all three sources in one edge; going below zero clamps and flags.
    assign w_uf_vec[g]    = (w_dn > w_up);
    assign w_count_nxt[g] = (w_dn > w_up) ? 2'd0 : 2'(w_up - w_dn);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the counter table is a small flop array, so it is cleared by reset rather than left unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_underflow <= r_underflow | (|w_uf_vec);
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < NREG; i++) busy[i] = (r_count[i] != 2'd0);
  end

  assign underflow = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: reset, RAW, r0, saturation,
// simultaneous updates, underflow and asynchronous mid-traffic reset.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issueValid;
  logic [2:0] issueOp1, issueOp2, issueDst, wbAddr, killAddr;
  logic       issueWriteEn, wbWriteEn, killValid;
  logic       issueReady, stall, underflow;
  logic [7:0] busy;

  int n_vec = 0;
  int n_err = 0;

  reg_scoreboard #(.rfWidth(3), .maxPend(3)) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueOp1(issueOp1), .issueOp2(issueOp2),
    .issueWriteEn(issueWriteEn), .issueDst(issueDst),
    .issueReady(issueReady), .stall(stall),
    .wbWriteEn(wbWriteEn), .wbAddr(wbAddr),
    .killValid(killValid), .killAddr(killAddr),
    .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge, clear all inputs, leave the caller to set the cycle's stimulus.
  task automatic next_cycle();
    @(negedge clk);
    issueValid = 1'b0; issueWriteEn = 1'b0;
    issueOp1 = '0; issueOp2 = '0; issueDst = '0;
    wbWriteEn = 1'b0; wbAddr = '0; killValid = 1'b0; killAddr = '0;
  endtask

  task automatic issue_wr(input logic [2:0] dst);
    issueValid = 1'b1; issueWriteEn = 1'b1; issueDst = dst;
  endtask

  initial begin
    rst = 1'b1;
    issueValid = 1'b0; issueWriteEn = 1'b0;
    issueOp1 = '0; issueOp2 = '0; issueDst = '0;
    wbWriteEn = 1'b0; wbAddr = '0; killValid = 1'b0; killAddr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    next_cycle(); rst = 1'b0;
    issueValid = 1'b1; issueOp1 = 3'd3; #1;
    check("rst_busy", busy, 8'h00);
    check("rst_uf", underflow, 0);
    check("rst_stall", stall, 0);

    // RAW on r3: write accepted in cycle 0, read stalls until wb at cycle 4
    next_cycle(); issue_wr(3'd3); #1;
    check("raw_acc", issueReady, 1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); issueValid = 1'b1; issueOp1 = 3'd3; #1;
      check("raw_stall", stall, 1);
    end
    check("raw_busy3", busy, 8'h08);
    next_cycle(); issueValid = 1'b1; issueOp1 = 3'd3; wbWriteEn = 1'b1; wbAddr = 3'd3; #1;
    check("raw_wb_same_cycle", stall, 1);
    next_cycle(); issueValid = 1'b1; issueOp1 = 3'd3; #1;
    check("raw_release", stall, 0);
    check("raw_busy_clear", busy, 8'h00);

    // Register zero: writes and reads never stall or mark busy
    for (int k = 0; k < 5; k++) begin
      next_cycle(); issue_wr(3'd0); #1;
      check("r0_wr_stall", stall, 0);
    end
    next_cycle(); issueValid = 1'b1; issueOp1 = 3'd0; issueOp2 = 3'd0; #1;
    check("r0_rd_stall", stall, 0);
    check("r0_busy", busy, 8'h00);

    // Saturation on r5
    for (int k = 0; k < 3; k++) begin
      next_cycle(); issue_wr(3'd5); #1;
      check("sat_fill", stall, 0);
    end
    next_cycle(); issue_wr(3'd5); #1;
    check("sat_4th_stall", stall, 1);
    check("sat_busy5", busy, 8'h20);
    next_cycle(); issue_wr(3'd5); wbWriteEn = 1'b1; wbAddr = 3'd5; #1;
    check("sat_wb_cycle", stall, 1);
    next_cycle(); issue_wr(3'd5); #1;
    check("sat_4th_issue", stall, 0);
    next_cycle(); issue_wr(3'd5); #1;
    check("sat_back_to_3", stall, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); wbWriteEn = 1'b1; wbAddr = 3'd5;
    end
    next_cycle(); #1;
    check("sat_drained", busy, 8'h00);
    check("sat_no_uf", underflow, 0);

    // Simultaneous accept + wb on r2 keeps count 1; then +1 then wb+kill gives 0
    next_cycle(); issue_wr(3'd2);
    next_cycle(); issue_wr(3'd2); wbWriteEn = 1'b1; wbAddr = 3'd2; #1;
    check("sim_ready", issueReady, 1);
    next_cycle(); #1;
    check("sim_busy2", busy, 8'h04);
    issue_wr(3'd2);
    next_cycle(); wbWriteEn = 1'b1; wbAddr = 3'd2; killValid = 1'b1; killAddr = 3'd2; #1;
    check("sim_cnt2_busy", busy, 8'h04);
    next_cycle(); #1;
    check("sim_cnt0", busy, 8'h00);
    check("sim_no_uf", underflow, 0);

    // Own-destination read checks pre-edge state; increment is seen next cycle
    next_cycle(); issue_wr(3'd4); issueOp1 = 3'd4; #1;
    check("self_rd_ready", issueReady, 1);
    next_cycle(); issueValid = 1'b1; issueOp2 = 3'd4; #1;
    check("self_next_stall", stall, 1);
    check("self_busy4", busy, 8'h10);
    wbWriteEn = 1'b1; wbAddr = 3'd4;

    // Register-zero decrements never flag underflow
    next_cycle(); wbWriteEn = 1'b1; wbAddr = 3'd0; killValid = 1'b1; killAddr = 3'd0;
    next_cycle(); #1;
    check("r0_dec_uf", underflow, 0);
    check("r0_dec_busy", busy, 8'h00);

    // Underflow: wb r6 at count 0, sticky through further traffic
    wbWriteEn = 1'b1; wbAddr = 3'd6; #1;
    check("uf_before", underflow, 0);
    next_cycle(); #1;
    check("uf_set", underflow, 1);
    check("uf_busy", busy, 8'h00);
    issue_wr(3'd1);
    next_cycle(); wbWriteEn = 1'b1; wbAddr = 3'd1;
    next_cycle(); #1;
    check("uf_sticky", underflow, 1);

    // Asynchronous reset mid-traffic clears everything immediately
    issue_wr(3'd7);
    next_cycle(); issue_wr(3'd1);
    next_cycle(); issueValid = 1'b1; issueOp1 = 3'd7; #1;
    check("mid_pre_busy", busy, 8'h82);
    check("mid_pre_stall", stall, 1);
    #2 rst = 1'b1; #1;
    check("mid_rst_busy", busy, 8'h00);
    check("mid_rst_uf", underflow, 0);
    check("mid_rst_stall", stall, 0);
    repeat (2) @(posedge clk);
    next_cycle(); rst = 1'b0; issueValid = 1'b1; issueOp1 = 3'd7; #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_busy", busy, 8'h00);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
